// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path: baud settings that
// match rs232_uart_tx, the default byte width, and the arbiter state encoding.
package uart_pkg;

    localparam int CLK_IN_HZ  = 50_000_000;
    localparam int BAUD_RATE  = 115_200;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: the winner is the first asserted
// req_valid bit found searching ptr+1, ptr+2, ... modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    // Scan from farthest to nearest so the nearest candidate is written last.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid[IDX_W'((int'(ptr) + k) % N_REQ)]) begin
                winner    = IDX_W'((int'(ptr) + k) % N_REQ);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one rs232_uart_tx core among N_REQ byte producers;
// sequences send/busy one byte at a time and flags a core that never goes busy.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     tx_send,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy,
    output logic                     arb_busy,
    output logic                     err_timeout,
    output logic [1:0]               dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             grab;
    logic             to_err;

    rr_pick #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_rr_pick (
        .req_valid(req_valid),
        .ptr      (ptr),
        .winner   (winner),
        .any_valid(any_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Handshake: a requester holds req_valid/req_data until it sees its
    // req_ready bit high at a clock edge; that edge is the transfer, and the
    // arbiter only looks at req_valid while in IDLE.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        grab      = 1'b0;
        to_err    = 1'b0;
        req_ready = '0;
        tx_send   = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_busy && any_valid) begin
                    grab    = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                tx_send   = 1'b1;
                req_ready = N_REQ'(1) << grant_idx;
                cnt_n     = '0;
                state_n   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    // Byte is dropped: no retry, the requester was already acked.
                    to_err  = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            ptr         <= IDX_W'(N_REQ - 1);
            grant_idx   <= '0;
            tx_data     <= '0;
            err_timeout <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            err_timeout <= to_err;
            if (grab) begin
                tx_data   <= req_data[int'(winner)*DATA_W +: DATA_W];
                grant_idx <= winner;
                ptr       <= winner;
            end
        end
    end

    assign arb_busy  = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small rs232_uart_tx busy model.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [1:0]  grant_idx;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        arb_busy;
    logic        err_timeout;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Core model: goes busy for core_len cycles after each accepted tx_send.
    logic core_en = 1'b1;
    logic force_busy = 1'b0;
    int   core_len = 3;
    int   core_cnt;

    int         got_idx_q[$];
    logic [7:0] got_dat_q[$];
    logic [7:0] exp_q[$];
    int         send_cnt;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) core_cnt <= 0;
        else if (core_en && tx_send) core_cnt <= core_len;
        else if (core_cnt != 0) core_cnt <= core_cnt - 1;
    end
    assign tx_busy = force_busy | (core_cnt != 0);

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant_idx(grant_idx), .tx_send(tx_send),
        .tx_data(tx_data), .tx_busy(tx_busy), .arb_busy(arb_busy),
        .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_data = '0;
        force_busy = 1'b0; core_en = 1'b1; core_len = 3;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        got_idx_q.delete(); got_dat_q.delete(); exp_q.delete();
        send_cnt = 0;
    endtask

    // Requester driver: logs grants and drops valid after the accepting edge
    // unless that requester is marked as holding.
    task automatic run_cycles(input int n, input logic [3:0] hold);
        logic [3:0] rdy;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rdy = req_ready;
            for (int i = 0; i < 4; i++)
                if (rdy[i]) begin got_idx_q.push_back(i); got_dat_q.push_back(tx_data); end
            if (tx_send) send_cnt++;
            @(posedge clk); #1;
            req_valid = req_valid & ~(rdy & ~hold);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); @(negedge clk);
        n_checks++; if (req_ready !== 4'b0) begin n_errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        n_checks++; if (tx_send !== 1'b0) begin n_errors++; $display("FAIL reset_send got %b exp 0", tx_send); end
        n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b exp 0", err_timeout); end
        n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_data got %h exp 00", tx_data); end
        n_checks++; if (grant_idx !== 2'd0) begin n_errors++; $display("FAIL reset_grant got %0d exp 0", grant_idx); end
        n_checks++; if (arb_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", arb_busy); end
        n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int busy_cycles;
        do_reset();
        req_data[2*8 +: 8] = 8'hA5;
        req_valid = 4'b0100;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL single_early got %b exp 0000", req_ready); end
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
        n_checks++; if (tx_send !== 1'b1) begin n_errors++; $display("FAIL single_send got %b exp 1", tx_send); end
        n_checks++; if (tx_data !== 8'hA5) begin n_errors++; $display("FAIL single_data got %h exp a5", tx_data); end
        n_checks++; if (grant_idx !== 2'd2) begin n_errors++; $display("FAIL single_grant got %0d exp 2", grant_idx); end
        @(posedge clk); #1;
        req_valid = '0;
        busy_cycles = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!arb_busy) break;
            busy_cycles++;
        end
        // SEND + WAIT_BUSY + 3 WAIT_DONE (2 busy, 1 seeing busy low)
        n_checks++; if (busy_cycles != 5) begin n_errors++; $display("FAIL single_busy_len got %0d exp 5", busy_cycles); end
        n_checks++; if (tx_data !== 8'hA5) begin n_errors++; $display("FAIL single_data_hold got %h exp a5", tx_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        int cnt_per[4];
        do_reset();
        req_data = 32'h13121110;
        req_valid = 4'b1111;
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        run_cycles(40, 4'b0000);
        n_checks++; if (got_idx_q.size() != 4) begin n_errors++; $display("FAIL simul_count got %0d exp 4", got_idx_q.size()); end
        n_checks++; if (send_cnt != 4) begin n_errors++; $display("FAIL simul_sends got %0d exp 4", send_cnt); end
        for (int k = 0; k < 4; k++) cnt_per[k] = 0;
        foreach (got_idx_q[k]) cnt_per[got_idx_q[k]]++;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (cnt_per[k] != 1) begin n_errors++; $display("FAIL simul_once[%0d] got %0d exp 1", k, cnt_per[k]); end
        end
        for (int k = 0; k < 4 && k < got_idx_q.size(); k++) begin
            n_checks++; if (got_idx_q[k] != k) begin n_errors++; $display("FAIL simul_order[%0d] got %0d exp %0d", k, got_idx_q[k], k); end
            n_checks++; if (got_dat_q[k] !== exp_q[k]) begin n_errors++; $display("FAIL simul_data[%0d] got %h exp %h", k, got_dat_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_fairness();
        int exp_idx[6] = '{1, 3, 1, 3, 1, 3};
        int bad;
        do_reset();
        req_data = 32'hD3C2B1A0;
        req_valid = 4'b1010;
        run_cycles(40, 4'b1010);
        req_valid = '0;
        n_checks++; if (got_idx_q.size() < 6) begin n_errors++; $display("FAIL fair_count got %0d exp >=6", got_idx_q.size()); end
        for (int k = 0; k < 6 && k < got_idx_q.size(); k++) begin
            n_checks++; if (got_idx_q[k] != exp_idx[k]) begin n_errors++; $display("FAIL fair_order[%0d] got %0d exp %0d", k, got_idx_q[k], exp_idx[k]); end
        end
        bad = 0;
        foreach (got_idx_q[k]) if (got_idx_q[k] == 0 || got_idx_q[k] == 2) bad++;
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL fair_idle_grants got %0d exp 0", bad); end
    endtask

    task automatic test_timeout();
        logic [3:0] rdy;
        do_reset();
        core_en = 1'b0;
        req_data[7:0] = 8'h55;
        req_valid = 4'b0001;
        // c1 SEND, c2..c5 WAIT_BUSY, c6 err pulse back in IDLE
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rdy = req_ready;
            n_checks++; if (rdy !== ((c == 1) ? 4'b0001 : 4'b0000)) begin n_errors++; $display("FAIL to_ready c%0d got %b", c, rdy); end
            n_checks++; if (tx_send !== (c == 1)) begin n_errors++; $display("FAIL to_send c%0d got %b", c, tx_send); end
            n_checks++; if (err_timeout !== (c == 6)) begin n_errors++; $display("FAIL to_err c%0d got %b exp %b", c, err_timeout, (c == 6)); end
            n_checks++; if (arb_busy !== (c >= 1 && c <= 5)) begin n_errors++; $display("FAIL to_busy c%0d got %b", c, arb_busy); end
            n_checks++; if (c == 1 && tx_data !== 8'h55) begin n_errors++; $display("FAIL to_data got %h exp 55", tx_data); end
            @(posedge clk); #1;
            req_valid = req_valid & ~rdy;
        end
        req_data[15:8] = 8'h77;
        req_valid = 4'b0010;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL to_next_early got %b exp 0000", req_ready); end
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL to_next_ready got %b exp 0010", req_ready); end
        n_checks++; if (tx_data !== 8'h77) begin n_errors++; $display("FAIL to_next_data got %h exp 77", tx_data); end
        n_checks++; if (grant_idx !== 2'd1) begin n_errors++; $display("FAIL to_next_grant got %0d exp 1", grant_idx); end
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic test_ext_busy();
        do_reset();
        force_busy = 1'b1;
        req_data[15:8] = 8'h3C;
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (req_ready !== 4'b0000 || arb_busy !== 1'b0) begin n_errors++; $display("FAIL xb_hold c%0d ready %b busy %b exp 0000 0", c, req_ready, arb_busy); end
            @(posedge clk); #1;
        end
        force_busy = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL xb_early got %b exp 0000", req_ready); end
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL xb_ready got %b exp 0010", req_ready); end
        n_checks++; if (tx_send !== 1'b1) begin n_errors++; $display("FAIL xb_send got %b exp 1", tx_send); end
        n_checks++; if (tx_data !== 8'h3C) begin n_errors++; $display("FAIL xb_data got %h exp 3c", tx_data); end
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] r;
        logic [1:0] st;
        logic found;
        do_reset();
        core_len = 8;
        req_data[23:16] = 8'h99;
        req_valid = 4'b0100;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            r = req_ready; st = dbg_state;
            @(posedge clk); #1;
            if (r != 0) req_valid = '0;
            if (st == 2'd3) found = 1'b1;
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL rm_reach_wait_done got state %0d exp 3", dbg_state); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++; if (req_ready !== 4'b0 || tx_send !== 1'b0 || err_timeout !== 1'b0) begin n_errors++; $display("FAIL rm_pulses got %b %b %b exp 0000 0 0", req_ready, tx_send, err_timeout); end
        n_checks++; if (tx_data !== 8'h00 || grant_idx !== 2'd0) begin n_errors++; $display("FAIL rm_regs got %h %0d exp 00 0", tx_data, grant_idx); end
        n_checks++; if (arb_busy !== 1'b0 || dbg_state !== 2'd0) begin n_errors++; $display("FAIL rm_state got busy %b state %0d exp 0 0", arb_busy, dbg_state); end
        @(posedge clk); #1;
        rst = 1'b0;
        req_data[7:0] = 8'hA0; req_data[31:24] = 8'hA3;
        req_valid = 4'b1001;
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL rm_early got %b exp 0000", req_ready); end
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL rm_first got %b exp 0001", req_ready); end
        n_checks++; if (tx_data !== 8'hA0 || grant_idx !== 2'd0) begin n_errors++; $display("FAIL rm_first_data got %h %0d exp a0 0", tx_data, grant_idx); end
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_ext_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one rs232_uart_tx core among N_REQ byte producers, for example a switch/key sender, a status reporter and an echo path.
- Accepts one byte per grant over a valid/ready handshake.
- Drives the core's send/tx_data/tx_busy interface and sequences one byte at a time.
- Flags a core that fails to acknowledge a send.
- Sits between the producers and rs232_uart_tx, in the same clk domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; must equal the core's tx_data width
ACK_TIMEOUT, 4, cycles allowed in WAIT_BUSY for tx_busy to rise after tx_send

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst  in  1  synchronous reset, active-high
req_valid  in  N_REQ  per-requester byte available; held until req_ready
req_data  in  N_REQ*DATA_W  requester i's byte at [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  one-cycle accept pulse, one-hot
grant_idx  out  clog2(N_REQ)  index of the last/current granted requester
tx_send  out  1  to core send; one-cycle pulse
tx_data  out  DATA_W  to core tx_data; registered, stable from tx_send until the next grant
tx_busy  in  1  from core tx_busy
arb_busy  out  1  high in every state except IDLE
err_timeout  out  1  one-cycle pulse when tx_busy does not rise within ACK_TIMEOUT

Behaviour:
- Reset, synchronous, overrides everything, valid in any state:
  - state=IDLE
  - req_ready=0, tx_send=0, err_timeout=0
  - tx_data=0, grant_idx=0
  - rr pointer=N_REQ-1, so requester 0 has first priority
  - timeout counter=0
- Reset mid-byte abandons the sequence; the core is reset by the same rst.
- Four-state FSM: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If tx_busy=0 and |req_valid: winner w = first asserted index searching ptr+1, ptr+2, ... modulo N_REQ.
  - Register tx_data<=req_data[w], grant_idx<=w, ptr<=w; go to SEND.
  - If tx_busy=1, stay in IDLE, even with requests pending.
- SEND (exactly 1 cycle): tx_send=1 and req_ready[w]=1 in this same cycle; go to WAIT_BUSY, counter cleared.
- Requester handshake: the requester samples req_ready at the clock edge and removes or changes valid/data from the next cycle on.
- Arbiter latency: byte accepted 1 cycle after IDLE sees valid; tx_send is in the same cycle as req_ready.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise increment the counter; on reaching ACK_TIMEOUT, pulse err_timeout for 1 cycle and return to IDLE.
  - The byte is considered lost; no retry and no re-ack.
- WAIT_DONE: wait for tx_busy=0, meaning the core has moved the byte into its shift register, then go to IDLE. No timeout here; the core can take up to about 2 bit periods.
- Minimum spacing between tx_send pulses: 4 cycles plus the core busy time.
- Fairness: a continuously requesting source waits at most N_REQ-1 grants.
- A sole requester may be granted back-to-back.
- req_valid changes outside IDLE are ignored; no sampling occurs outside IDLE.
- Width rule: the pointer wraps modulo N_REQ, including non-power-of-2 values.

Decomposition:
- Shared package uart_pkg holds:
  - CLK_IN_HZ and BAUD_RATE constants, matching the core
  - the state enum {IDLE, SEND, WAIT_BUSY, WAIT_DONE}
  - DATA_W default
- One natural sub-module: rr_pick, a combinational round-robin priority encoder. It takes req_valid and ptr and returns winner index and any_valid. It is unit-testable separately.

Test Plan:
- Single byte: req_valid[2]=1 with data 0xA5, core modelled. Expect req_ready[2] and tx_send in the same cycle, 1 cycle after valid; tx_data=0xA5; grant_idx=2; arb_busy high until tx_busy falls.
- Simultaneous four: all valid with data 0x10,0x11,0x12,0x13 held until acked. Expect tx_send order 0,1,2,3; each req_ready pulsed exactly once.
- Fairness: requesters 1 and 3 held permanently valid after reset. Expect grant sequence 1,3,1,3,1,3; no grants to 0 or 2.
- Timeout: tx_busy tied 0, req_valid[0]=1 with data 0x55. Expect req_ready[0] and tx_send once, err_timeout pulse 4 cycles after WAIT_BUSY entry, then IDLE; the next valid is granted normally.
- External busy: tx_busy forced 1 with req_valid[1]=1. Expect no grant until tx_busy drops; grant 1 cycle after tx_busy=0.
- Reset mid-operation: assert rst in WAIT_DONE. Next cycle expect all outputs 0 and arb_busy=0; the first grant after reset, with 0 and 3 valid, goes to 0.
